gate_bist_ctrl: RTL and testbench
=================================

Name: gate_bist_ctrl

Overview:
- Self-test sequencer for a small combinational gate under test, e.g. the 2-input OR.
- Drives every input vector onto the gate in ascending order and waits a programmable settle time.
- Samples the gate output and compares it with an expected truth table latched at start.
- Reports pass/fail, mismatch count and first failing vector. Sits between a test/config master and one gate instance.

Parameters:
- N_IN, 2, number of gate inputs; vector space is 2**N_IN.
- SETTLE, 2, cycles waited after applying a vector before sampling; legal 1..15.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request a run; accepted only in IDLE.
- abort  in  1  synchronous abort of a run in progress.
- expected_tt  in  2**N_IN  bit i = expected gate output for vector i; latched on start accept.
- gate_in  out  N_IN  registered vector to the gate; bit N_IN-1 = first gate input (a).
- gate_out  in  1  gate output under test.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse at end of run.
- pass  out  1  1 when the last completed run had zero mismatches.
- err_count  out  N_IN+1  mismatches in the current or last run.
- fail_valid  out  1  at least one mismatch recorded.
- first_fail_vec  out  N_IN  vector of the first mismatch; valid when fail_valid=1.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, gate_in=0, busy=0, done=0, pass=0, err_count=0, fail_valid=0, first_fail_vec=0, vec=0, settle counter=0.
- FSM states: IDLE, APPLY, SETTLE, CHECK, DONE.
- IDLE: start=1 at an edge does all of the following, then goes to APPLY:
  - latches expected_tt;
  - clears err_count, fail_valid and first_fail_vec;
  - sets vec=0.
- APPLY: 1 cycle. gate_in<=vec. Goes to SETTLE with counter=SETTLE-1.
- SETTLE: counter decrements each cycle. Goes to CHECK when counter=0, so SETTLE cycles are spent here.
- CHECK: 1 cycle. Compares gate_out with tt_latched[vec].
  - On mismatch: err_count+1. If fail_valid=0, first_fail_vec<=vec and fail_valid<=1.
  - If vec=2**N_IN-1, goes to DONE; otherwise vec+1, then APPLY.
- DONE: 1 cycle. done=1, pass<=(err_count==0, including a CHECK mismatch in the final cycle), then IDLE.
- Per-vector cost: SETTLE+2 cycles. For defaults, done is high in the 17th cycle after the start edge.
- gate_in holds its last vector after a run; there is no wrap back to 0 until the next start.
- start while busy: ignored, no effect on vec or counters.
- abort=1 in APPLY, SETTLE or CHECK: next state IDLE, no done pulse. pass is unchanged; err_count and fail_valid hold partial values. A CHECK in the same cycle as abort is discarded.
- abort in DONE: DONE completes normally (done pulses).
- start and abort together in IDLE: start wins, abort is ignored.
- Reset mid-run: immediate return to reset values; no done pulse.
- err_count width N_IN+1 holds the maximum 2**N_IN without overflow.

Optional Feature:
- Macro GATE_BIST_STOP_ON_FAIL_EN.
- Defined: the first mismatch in CHECK sends the FSM directly to DONE. err_count=1, pass=0, remaining vectors are not applied.
- Undefined: all 2**N_IN vectors are always applied.

Test Plan:
- Correct OR gate, expected_tt=4'b1110, defaults: start pulse -> gate_in steps 00,01,10,11 every 4 cycles; done pulse 17 cycles after start; pass=1, err_count=0, fail_valid=0.
- Gate output stuck at 0, expected_tt=4'b1110 (macro off): done pulse at cycle 17; err_count=3, first_fail_vec=2'b01, pass=0.
- Same stuck-at-0 run with GATE_BIST_STOP_ON_FAIL_EN: done pulse at cycle 9, err_count=1, first_fail_vec=2'b01, gate_in=2'b01, pass=0.
- start re-asserted at cycle 5 of a run: no restart; done still at cycle 17; abort at cycle 6 of a fresh run -> busy=0 next cycle, no done, pass keeps its previous value.
- rst_n low at cycle 7: all outputs at reset values asynchronously. After release, start with expected_tt=4'b1110 and a correct gate -> pass=1.
- SETTLE=5 override, correct gate: gate_in changes every 7 cycles; done 29 cycles after start.

Source files
------------

// File: rtl/gate_bist_ctrl.sv
// Self-test sequencer: walks every input vector through a small combinational gate and
// checks the output against a truth table. Optional macro GATE_BIST_STOP_ON_FAIL_EN ends a run at the first mismatch.
module gate_bist_ctrl #(
    parameter int unsigned N_IN   = 2,
    parameter int unsigned SETTLE = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      abort,
    input  logic [(2**N_IN)-1:0]      expected_tt,
    output logic [N_IN-1:0]           gate_in,
    input  logic                      gate_out,
    output logic                      busy,
    output logic                      done,
    output logic                      pass,
    output logic [N_IN:0]             err_count,
    output logic                      fail_valid,
    output logic [N_IN-1:0]           first_fail_vec
);

    localparam int unsigned NVEC = 2 ** N_IN;
    localparam int unsigned CW   = 4;
    localparam int unsigned EW   = N_IN + 1;

`ifdef GATE_BIST_STOP_ON_FAIL_EN
    localparam bit STOP_ON_FAIL = 1'b1;
`else
    localparam bit STOP_ON_FAIL = 1'b0;
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_APPLY,
        ST_SETTLE,
        ST_CHECK,
        ST_DONE
    } state_t;

    state_t             state;
    logic [NVEC-1:0]    tt;
    logic [N_IN-1:0]    vec;
    logic [CW-1:0]      cnt;

    logic               mismatch;
    logic [EW-1:0]      err_next;
    logic               run_end;

    // Comparison of the sampled gate output against the latched truth table.
    assign mismatch = (gate_out != tt[vec]);
    assign err_next = err_count + EW'(mismatch);
    assign run_end  = (vec == N_IN'(NVEC - 1)) || (STOP_ON_FAIL && mismatch);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            tt             <= '0;
            vec            <= '0;
            cnt            <= '0;
            gate_in        <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            fail_valid     <= 1'b0;
            first_fail_vec <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        tt             <= expected_tt;
                        err_count      <= '0;
                        fail_valid     <= 1'b0;
                        first_fail_vec <= '0;
                        vec            <= '0;
                        busy           <= 1'b1;
                        state          <= ST_APPLY;
                    end
                end
                ST_APPLY: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        gate_in <= vec;
                        cnt     <= CW'(SETTLE - 1);
                        state   <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else if (cnt == '0) begin
                        state <= ST_CHECK;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                ST_CHECK: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        if (mismatch) begin
                            err_count <= err_next;
                            if (!fail_valid) begin
                                fail_valid     <= 1'b1;
                                first_fail_vec <= vec;
                            end
                        end
                        // pass uses the updated count so a final-vector mismatch is included.
                        if (run_end) begin
                            done  <= 1'b1;
                            pass  <= (err_next == '0);
                            state <= ST_DONE;
                        end else begin
                            vec   <= vec + N_IN'(1);
                            state <= ST_APPLY;
                        end
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Directed bench for gate_bist_ctrl driving a modelled 2-input OR gate (optionally stuck at 0).
module tb_gate_bist_ctrl;

    logic       clk;
    logic       rst_n;
    int         checks;
    int         errors;
    int         cyc;

    logic       start, abort, fault;
    logic [3:0] expected_tt;
    logic [1:0] gate_in;
    logic       gate_out, busy, done, pass, fail_valid;
    logic [2:0] err_count;
    logic [1:0] first_fail_vec;

    logic       start5, abort5;
    logic [3:0] expected_tt5;
    logic [1:0] gate_in5;
    logic       gate_out5, busy5, done5, pass5, fail_valid5;
    logic [2:0] err_count5;
    logic [1:0] first_fail_vec5;

`ifdef GATE_BIST_STOP_ON_FAIL_EN
    localparam int FAIL_DONE_CYC = 9;
    localparam int FAIL_ERRS     = 1;
`else
    localparam int FAIL_DONE_CYC = 17;
    localparam int FAIL_ERRS     = 3;
`endif

    gate_bist_ctrl #(.N_IN(2), .SETTLE(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .expected_tt(expected_tt), .gate_in(gate_in), .gate_out(gate_out),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .fail_valid(fail_valid), .first_fail_vec(first_fail_vec)
    );

    gate_bist_ctrl #(.N_IN(2), .SETTLE(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .start(start5), .abort(abort5),
        .expected_tt(expected_tt5), .gate_in(gate_in5), .gate_out(gate_out5),
        .busy(busy5), .done(done5), .pass(pass5), .err_count(err_count5),
        .fail_valid(fail_valid5), .first_fail_vec(first_fail_vec5)
    );

    // OR gate: a = gate_in[1], b = gate_in[0].
    assign gate_out  = fault ? 1'b0 : (gate_in[1] | gate_in[0]);
    assign gate_out5 = gate_in5[1] | gate_in5[0];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int target);
        while (cyc < target) tick();
    endtask

    task automatic do_start(input logic [3:0] tt);
        expected_tt = tt;
        start = 1'b1;
        cyc = 0;
        tick();
        start = 1'b0;
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; fault = 1'b0; expected_tt = 4'b0;
        start5 = 1'b0; abort5 = 1'b0; expected_tt5 = 4'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_pass", 32'(pass), 0);
        check("rst_err", 32'(err_count), 0);
        check("rst_fv", 32'(fail_valid), 0);
        check("rst_gate_in", 32'(gate_in), 0);
        rst_n = 1'b1;
        tick();

        // Correct OR gate, full run.
        do_start(4'b1110);
        check("t1_busy_c1", 32'(busy), 1);
        run_to(2);  check("t1_vec0", 32'(gate_in), 0);
        run_to(6);  check("t1_vec1", 32'(gate_in), 1);
        run_to(10); check("t1_vec2", 32'(gate_in), 2);
        run_to(14); check("t1_vec3", 32'(gate_in), 3);
        run_to(16); check("t1_done_c16", 32'(done), 0);
        run_to(17);
        check("t1_done_c17", 32'(done), 1);
        check("t1_pass", 32'(pass), 1);
        check("t1_err", 32'(err_count), 0);
        check("t1_fv", 32'(fail_valid), 0);
        run_to(18);
        check("t1_done_c18", 32'(done), 0);
        check("t1_busy_c18", 32'(busy), 0);
        check("t1_hold_vec", 32'(gate_in), 3);

        // Stuck-at-0 gate.
        fault = 1'b1;
        do_start(4'b1110);
        run_to(FAIL_DONE_CYC - 1); check("t2_done_early", 32'(done), 0);
        run_to(FAIL_DONE_CYC);
        check("t2_done", 32'(done), 1);
        check("t2_err", 32'(err_count), 32'(FAIL_ERRS));
        check("t2_ffv", 32'(first_fail_vec), 1);
        check("t2_fv", 32'(fail_valid), 1);
        check("t2_pass", 32'(pass), 0);
`ifdef GATE_BIST_STOP_ON_FAIL_EN
        check("t2_gate_in", 32'(gate_in), 1);
`else
        check("t2_gate_in", 32'(gate_in), 3);
`endif
        run_to(FAIL_DONE_CYC + 2);

        // start re-asserted mid-run is ignored.
        fault = 1'b0;
        do_start(4'b1110);
        run_to(5); start = 1'b1;
        run_to(6); start = 1'b0;
        check("t3_vec1_no_restart", 32'(gate_in), 1);
        run_to(16); check("t3_done_c16", 32'(done), 0);
        run_to(17);
        check("t3_done_c17", 32'(done), 1);
        check("t3_pass", 32'(pass), 1);
        run_to(19);

        // Abort in SETTLE of vector 1, with a faulty gate; pass must keep its 1.
        fault = 1'b1;
        do_start(4'b1110);
        run_to(6); abort = 1'b1;
        run_to(7); abort = 1'b0;
        check("t4_busy", 32'(busy), 0);
        check("t4_pass_kept", 32'(pass), 1);
        check("t4_err_partial", 32'(err_count), 0);
        for (int i = 0; i < 12; i++) begin
            check("t4_no_done", 32'(done), 0);
            tick();
        end
        check("t4_still_idle", 32'(busy), 0);

        // Asynchronous reset mid-run.
        do_start(4'b1110);
        run_to(7);
        check("t5_pre_busy", 32'(busy), 1);
        check("t5_pre_vec", 32'(gate_in), 1);
        rst_n = 1'b0;
        #1;
        check("t5_rst_busy", 32'(busy), 0);
        check("t5_rst_gate_in", 32'(gate_in), 0);
        check("t5_rst_pass", 32'(pass), 0);
        check("t5_rst_done", 32'(done), 0);
        check("t5_rst_err", 32'(err_count), 0);
        tick();
        check("t5_rst_held_done", 32'(done), 0);
        rst_n = 1'b1;
        fault = 1'b0;
        tick();
        do_start(4'b1110);
        run_to(17);
        check("t5_done", 32'(done), 1);
        check("t5_pass", 32'(pass), 1);
        run_to(19);

        // SETTLE=5 instance: 7 cycles per vector.
        expected_tt5 = 4'b1110;
        start5 = 1'b1;
        cyc = 0;
        tick();
        start5 = 1'b0;
        run_to(2);  check("t6_vec0", 32'(gate_in5), 0);
        run_to(8);  check("t6_vec0_hold", 32'(gate_in5), 0);
        run_to(9);  check("t6_vec1", 32'(gate_in5), 1);
        run_to(16); check("t6_vec2", 32'(gate_in5), 2);
        run_to(23); check("t6_vec3", 32'(gate_in5), 3);
        run_to(28); check("t6_done_c28", 32'(done5), 0);
        run_to(29);
        check("t6_done_c29", 32'(done5), 1);
        check("t6_pass", 32'(pass5), 1);
        check("t6_err", 32'(err_count5), 0);
        run_to(30);
        check("t6_idle", 32'(busy5), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
